// File: rtl/joy_md_serializer.sv
// Device-side model of two Mega Drive / Atari pads behind a 16-bit parallel-in/serial-out
// chain. The select line steps each pad through the Sega 6-button phase sequence.
`timescale 1ns/1ps
module joy_md_serializer #(
    parameter int TIMEOUT_CYCLES = 24000,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        joy_clk,
    input  logic        joy_load_n,
    input  logic        hsync_n_s,
    input  logic [11:0] joy1_i,
    input  logic [11:0] joy2_i,
    input  logic [1:0]  pad1_type,
    input  logic [1:0]  pad2_type,
    output logic        joy_data
);

    typedef enum logic [1:0] {
        PAD_ATARI = 2'b00,
        PAD_MD3   = 2'b01,
        PAD_MD6   = 2'b10,
        PAD_NONE  = 2'b11
    } pad_type_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            clk_s1_q, clk_s2_q, clk_h_q;
    logic            ld_s1_q, ld_s2_q;
    logic            sel_q;
    logic [15:0]     sr_q, sr_d;
    logic [2:0]      cnt_q [2];
    logic [2:0]      cnt_d [2];
    logic [TO_W-1:0] to_q  [2];
    logic [TO_W-1:0] to_d  [2];

    logic        clk_rise, sel_fall, sel_edge;
    logic [5:0]  p1_pins, p2_pins;
    logic [15:0] load_img;

    // Pin levels as {up, down, left, right, pin6, pin9}; buttons are active low.
    function automatic logic [5:0] pad_pins(input logic [1:0] ptype, input logic sel,
                                            input logic [2:0] cnt, input logic [11:0] b);
        logic [2:0] ph;
        logic [5:0] pins;
        ph   = (ptype == PAD_MD3) ? 3'd1 : cnt;
        pins = '1;
        case (ptype)
            PAD_ATARI: pins = {b[0], b[1], b[2], b[3], b[4], b[5]};
            PAD_MD3, PAD_MD6: begin
                if (sel) begin
                    if (ph == 3'd3) pins = {b[8], b[9], b[10], b[11], b[4], b[5]};
                    else            pins = {b[0], b[1], b[2], b[3], b[4], b[5]};
                end else begin
                    case (ph)
                        3'd3:    pins = {4'b0000, b[6], b[7]};
                        3'd4:    pins = {4'b1111, b[6], b[7]};
                        default: pins = {b[0], b[1], 2'b00, b[6], b[7]};
                    endcase
                end
            end
            default: pins = '1;
        endcase
        return pins;
    endfunction

    assign clk_rise = clk_s2_q & ~clk_h_q;
    assign sel_fall = sel_q & ~hsync_n_s;
    assign sel_edge = sel_q ^ hsync_n_s;

    assign p1_pins  = pad_pins(pad1_type, hsync_n_s, cnt_q[0], joy1_i);
    assign p2_pins  = pad_pins(pad2_type, hsync_n_s, cnt_q[1], joy2_i);

    // sr_q[15] is chain position 0, so each pad's pins appear pin9-first.
    assign load_img = {2'b11, p1_pins[0], p1_pins[1], p1_pins[2], p1_pins[3], p1_pins[4], p1_pins[5],
                       2'b11, p2_pins[0], p2_pins[1], p2_pins[2], p2_pins[3], p2_pins[4], p2_pins[5]};

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            cnt_d[p] = cnt_q[p];
            to_d[p]  = to_q[p];
            if (sel_fall) begin
                cnt_d[p] = (cnt_q[p] == 3'd4) ? 3'd1 : cnt_q[p] + 3'd1;
                to_d[p]  = '0;
            end else if (sel_edge) begin
                to_d[p]  = '0;
            end else if (to_q[p] == TO_LAST) begin
                cnt_d[p] = 3'd0;
                to_d[p]  = '0;
            end else if (to_q[p] != '1) begin
                to_d[p]  = to_q[p] + 1'b1;
            end
        end
    end

    // Load wins over a coincident shift edge.
    always_comb begin
        sr_d = sr_q;
        if (!ld_s2_q)      sr_d = load_img;
        else if (clk_rise) sr_d = {sr_q[14:0], 1'b1};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_h_q  <= 1'b1;
            ld_s1_q  <= 1'b1;
            ld_s2_q  <= 1'b1;
            sel_q    <= 1'b1;
            sr_q     <= '1;
            for (int p = 0; p < 2; p++) begin
                cnt_q[p] <= 3'd0;
                to_q[p]  <= '0;
            end
        end else begin
            clk_s1_q <= joy_clk;
            clk_s2_q <= clk_s1_q;
            clk_h_q  <= clk_s2_q;
            ld_s1_q  <= joy_load_n;
            ld_s2_q  <= ld_s1_q;
            sel_q    <= hsync_n_s;
            sr_q     <= sr_d;
            for (int p = 0; p < 2; p++) begin
                cnt_q[p] <= cnt_d[p];
                to_q[p]  <= to_d[p];
            end
        end
    end

    assign joy_data = sr_q[15];

endmodule

// File: tb/tb_joy_md_serializer.sv
// Self-checking bench for joy_md_serializer: fixed vectors, hand-written phase sequences,
// and randomized frames checked against a pad-behaviour model.
`timescale 1ns/1ps
module tb_joy_md_serializer;

    localparam int T  = 1000;
    localparam int TW = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        joy_clk = 1'b0;
    logic        joy_load_n = 1'b1;
    logic        hsync_n_s = 1'b1;
    logic [11:0] joy1_i = '1;
    logic [11:0] joy2_i = '1;
    logic [1:0]  pad1_type = 2'b11;
    logic [1:0]  pad2_type = 2'b11;
    logic        joy_data;

    int checks = 0;
    int errors = 0;
    int m_phase = 0;

    always #5 clk = ~clk;

    joy_md_serializer #(.TIMEOUT_CYCLES(T), .TO_W(TW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .joy_clk    (joy_clk),
        .joy_load_n (joy_load_n),
        .hsync_n_s  (hsync_n_s),
        .joy1_i     (joy1_i),
        .joy2_i     (joy2_i),
        .pad1_type  (pad1_type),
        .pad2_type  (pad2_type),
        .joy_data   (joy_data)
    );

    typedef struct {
        logic [1:0]  t1;
        logic [1:0]  t2;
        logic [11:0] j1;
        logic [11:0] j2;
        logic        sel;
        logic [15:0] exp;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] exp6 [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pad model: {U, D, L, R, pin6, pin9} from the pad's phase-table rules.
    function automatic logic [5:0] m_pins(input logic [1:0] ty, input logic sel,
                                          input int ph, input logic [11:0] b);
        int eff;
        eff = (ty == 2'b01) ? 1 : ph;
        if (ty == 2'b11) return 6'h3F;
        if (ty == 2'b00 || (sel && eff != 3)) return {b[0], b[1], b[2], b[3], b[4], b[5]};
        if (sel) return {b[8], b[9], b[10], b[11], b[4], b[5]};
        if (eff == 3) return {4'h0, b[6], b[7]};
        if (eff == 4) return {4'hF, b[6], b[7]};
        return {b[0], b[1], 2'b00, b[6], b[7]};
    endfunction

    // Frame with bit [15 - pos] holding chain position pos.
    function automatic logic [15:0] m_frame(input logic sel, input int ph);
        logic [5:0]  a, c;
        logic [15:0] f;
        a = m_pins(pad1_type, sel, ph, joy1_i);
        c = m_pins(pad2_type, sel, ph, joy2_i);
        f = '1;
        for (int k = 0; k < 6; k++) begin
            f[15 - (2 + k)]  = a[k];
            f[15 - (10 + k)] = c[k];
        end
        return f;
    endfunction

    task automatic do_reset();
        hsync_n_s = 1'b1;
        reset_n   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_phase = 0;
        @(negedge clk);
    endtask

    task automatic set_sel(input logic v);
        if (hsync_n_s && !v) m_phase = (m_phase == 4) ? 1 : m_phase + 1;
        hsync_n_s = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_pulse();
        joy_load_n = 1'b0;
        repeat (3) @(negedge clk);
        joy_load_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic clk_pulse();
        joy_clk = 1'b1;
        repeat (4) @(negedge clk);
        joy_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_bits(input int n, output logic [15:0] v);
        v = '1;
        for (int i = 0; i < n; i++) begin
            v = {v[14:0], joy_data};
            clk_pulse();
        end
    endtask

    task automatic frame(input string name, input logic [15:0] exp);
        logic [15:0] v;
        load_pulse();
        read_bits(16, v);
        check(name, 32'(v), 32'(exp));
        check({name, "_tail"}, 32'(joy_data), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;

        tbl[0] = '{2'b00, 2'b11, 12'hFFE, 12'h000, 1'b1, 16'hFEFF};
        tbl[1] = '{2'b00, 2'b11, 12'h000, 12'hFFF, 1'b1, 16'hC0FF};
        tbl[2] = '{2'b11, 2'b00, 12'hFFF, 12'hFEF, 1'b1, 16'hFFEF};
        tbl[3] = '{2'b10, 2'b01, 12'hF0A, 12'hFFF, 1'b1, 16'hCAFF};
        tbl[4] = '{2'b01, 2'b10, 12'hF5F, 12'h0FF, 1'b1, 16'hDFFF};
        tbl[5] = '{2'b11, 2'b11, 12'h000, 12'h000, 1'b1, 16'hFFFF};
        tbl[6] = '{2'b10, 2'b00, 12'hF0A, 12'hFFF, 1'b0, 16'hC2FF};
        tbl[7] = '{2'b00, 2'b01, 12'hF0A, 12'hF3F, 1'b0, 16'hCAC3};
        exp6 = '{8'hFF, 8'hE3, 8'hFF, 8'hE3, 8'hFF, 8'hE0, 8'hF7, 8'hEF, 8'hFF};

        // Reset and idle.
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_data", 32'(joy_data), 32'd1);
        check("rst_cnt1", 32'(dut.cnt_q[0]), 32'd0);
        check("rst_cnt2", 32'(dut.cnt_q[1]), 32'd0);
        repeat (20) @(negedge clk);
        check("idle_data", 32'(joy_data), 32'd1);

        // Fixed vectors from a fresh reset.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            pad1_type = tbl[i].t1;
            pad2_type = tbl[i].t2;
            joy1_i    = tbl[i].j1;
            joy2_i    = tbl[i].j2;
            if (!tbl[i].sel) set_sel(1'b0);
            frame($sformatf("vec%0d", i), tbl[i].exp);
            set_sel(1'b1);
        end

        // 6-button sequence on pad 2: M and A pressed.
        do_reset();
        pad1_type = 2'b11;
        pad2_type = 2'b10;
        joy1_i    = 12'hFFF;
        joy2_i    = 12'h7BF;
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 1)  set_sel(1'b0);
            else if (i > 0)  set_sel(1'b1);
            frame($sformatf("six_%0d", i), {8'hFF, exp6[i]});
        end

        // Phase 3 exposes ZYXM, then timeout returns the pad to phase 0.
        do_reset();
        pad1_type = 2'b10;
        pad2_type = 2'b11;
        joy1_i    = 12'h0FF;
        joy2_i    = 12'hFFF;
        repeat (3) begin set_sel(1'b0); set_sel(1'b1); end
        frame("to_ph3", 16'hF0FF);

        do_reset();
        repeat (2) begin set_sel(1'b0); set_sel(1'b1); end
        set_sel(1'b0);
        hsync_n_s = 1'b1;
        repeat (T) @(posedge clk);
        #1;
        check("to_before", 32'(dut.cnt_q[0]), 32'd3);
        @(posedge clk);
        #1;
        check("to_after1", 32'(dut.cnt_q[0]), 32'd0);
        check("to_after2", 32'(dut.cnt_q[1]), 32'd0);
        @(negedge clk);
        m_phase = 0;
        frame("to_udlr", 16'hFFFF);

        // 3-button pad never exposes XYZM.
        do_reset();
        pad1_type = 2'b01;
        pad2_type = 2'b11;
        joy1_i    = 12'hF0C;
        frame("md3_hi0", 16'hCCFF);
        for (int i = 1; i <= 5; i++) begin
            set_sel(1'b0);
            frame($sformatf("md3_lo%0d", i), 16'hC0FF);
            set_sel(1'b1);
            frame($sformatf("md3_hi%0d", i), 16'hCCFF);
        end

        // Load and shift edge land in the same synchronised cycle: load wins.
        do_reset();
        pad1_type = 2'b00;
        pad2_type = 2'b11;
        joy1_i    = 12'hFFE;
        load_pulse();
        repeat (3) clk_pulse();
        joy_clk    = 1'b1;
        joy_load_n = 1'b0;
        @(negedge clk);
        joy_load_n = 1'b1;
        repeat (6) @(negedge clk);
        joy_clk = 1'b0;
        repeat (4) @(negedge clk);
        read_bits(16, v);
        check("collide", 32'(v), 32'hFEFF);
        check("collide_tail", 32'(joy_data), 32'd1);

        // Reset in the middle of a frame.
        do_reset();
        pad2_type = 2'b10;
        set_sel(1'b0);
        load_pulse();
        repeat (7) clk_pulse();
        check("mid_pos7", 32'(joy_data), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_data", 32'(joy_data), 32'd1);
        check("mid_rst_cnt", 32'({dut.cnt_q[0], dut.cnt_q[1]}), 32'd0);
        hsync_n_s = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        m_phase = 0;
        @(negedge clk);

        // Randomized frames against the model.
        for (int it = 0; it < 30; it++) begin
            int n;
            pad1_type = 2'($urandom_range(0, 3));
            pad2_type = 2'($urandom_range(0, 3));
            joy1_i    = 12'($urandom);
            joy2_i    = 12'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat (2 * T) @(negedge clk);
                m_phase = 0;
            end
            set_sel(!hsync_n_s);
            n = $urandom_range(0, 4);
            repeat (n) set_sel(1'($urandom_range(0, 1)));
            frame($sformatf("rand%0d", it), m_frame(hsync_n_s, m_phase));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
